// File: rtl/dmem_store_unit_pkg.sv
// dmem_store_unit_pkg: store opcodes, bus size codes and FSM encoding for the data-side write path
package dmem_store_unit_pkg;
  localparam logic [5:0] OP_SB = 6'b101000;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} state_e;
  function automatic logic is_store(input logic [5:0] op);
    return op == OP_SB || op == OP_SH || op == OP_SW;
  endfunction
endpackage

// File: rtl/dmem_store_unit_align.sv
// dmem_store_unit_align: byte-lane formatting and alignment check for SB/SH/SW
module dmem_store_unit_align
  import dmem_store_unit_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rt,
  output logic [1:0]  size,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        misalign
);
  always_comb begin
    size     = op == OP_SB ? SIZE_BYTE : op == OP_SH ? SIZE_HALF : SIZE_WORD;
    wdata    = op == OP_SB ? {4{rt[7:0]}} : op == OP_SH ? {2{rt[15:0]}} : rt;
    wstrb    = op == OP_SB ? 4'b0001 << addr_lo : op == OP_SH ? (addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    misalign = (op == OP_SH && addr_lo[0]) || (op == OP_SW && addr_lo != 2'b00);
  end
endmodule

// File: rtl/dmem_store_unit.sv
// dmem_store_unit: turns MEM-stage SB/SH/SW into sram-like write transactions and stalls until acknowledged
module dmem_store_unit
  import dmem_store_unit_pkg::*;
#(
  parameter logic [31:0] UNMAPPED_MASK = 32'h1FFF_FFFF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        st_valid,
  input  logic [5:0]  st_op,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_rt,
  input  logic        st_cancel,
  input  logic        flush,
  output logic        st_stall,
  output logic        st_ades,
  output logic [31:0] st_badvaddr,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_wstrb,
  input  logic        data_addr_ok,
  input  logic        data_data_ok
);
  state_e      state_q, state_d;
  logic [1:0]  size_q, size_d, fmt_size;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, fmt_wdata;
  logic [3:0]  wstrb_q, wstrb_d, fmt_wstrb;
  logic        store, misalign, start;

  dmem_store_unit_align u_align (
    .op       (st_op),
    .addr_lo  (st_addr[1:0]),
    .rt       (st_rt),
    .size     (fmt_size),
    .wdata    (fmt_wdata),
    .wstrb    (fmt_wstrb),
    .misalign (misalign)
  );

  assign store = is_store(st_op);
  assign start = state_q == S_IDLE && st_valid && store && !misalign && !st_cancel && !flush;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  // A flush only aborts a request the bus has not yet accepted; an accepted write always drains.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = start ? S_REQ : S_IDLE;
      S_REQ:   state_d = data_addr_ok ? (data_data_ok ? S_IDLE : S_WAIT) : (flush ? S_IDLE : S_REQ);
      S_WAIT:  state_d = data_data_ok ? S_IDLE : S_WAIT;
      default: state_d = S_IDLE;
    endcase
    size_d  = start ? fmt_size : size_q;
    addr_d  = start ? (st_addr[31:30] == 2'b10 ? st_addr & UNMAPPED_MASK : st_addr) : addr_q;
    wdata_d = start ? fmt_wdata : wdata_q;
    wstrb_d = start ? fmt_wstrb : wstrb_q;
  end

  // Stall drops in the completion cycle so the store leaves MEM exactly once.
  always_comb begin
    data_req    = state_q == S_REQ;
    data_wr     = data_req;
    data_size   = size_q;
    data_addr   = addr_q;
    data_wdata  = wdata_q;
    data_wstrb  = wstrb_q;
    st_ades     = st_valid && store && misalign && !st_cancel;
    st_badvaddr = st_ades ? st_addr : '0;
    st_stall    = start || (state_q == S_REQ && !(data_addr_ok && data_data_ok))
                  || (state_q == S_WAIT && !data_data_ok);
  end
endmodule

// File: tb/tb_dmem_store_unit.sv
// tb_dmem_store_unit: random pipeline driver + bus responder, scoreboarded against a behavioural store model
module tb_dmem_store_unit;
  localparam logic [5:0] SB = 6'b101000;
  localparam logic [5:0] SH = 6'b101001;
  localparam logic [5:0] SW = 6'b101011;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic [3:0]  wstrb;
  } req_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        st_valid = 1'b0, st_cancel = 1'b0, flush = 1'b0;
  logic [5:0]  st_op = '0;
  logic [31:0] st_addr = '0, st_rt = '0;
  logic        st_stall, st_ades, data_req, data_wr;
  logic [31:0] st_badvaddr, data_addr, data_wdata;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok = 1'b0, data_data_ok = 1'b0;

  int   chk = 0, err = 0;
  int   outstanding = 0;
  int   p_aok = 50, p_dok = 50;
  req_t q[$];

  logic        new_instr = 1'b1, cv = 1'b0, cc = 1'b0;
  logic [5:0]  cop = '0;
  logic [31:0] ca = '0, crt = '0;

  dmem_store_unit dut (
    .clk          (clk),
    .resetn       (resetn),
    .st_valid     (st_valid),
    .st_op        (st_op),
    .st_addr      (st_addr),
    .st_rt        (st_rt),
    .st_cancel    (st_cancel),
    .flush        (flush),
    .st_stall     (st_stall),
    .st_ades      (st_ades),
    .st_badvaddr  (st_badvaddr),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_wstrb   (data_wstrb),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk++;
    if (got !== exp) begin
      err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic is_st(input logic [5:0] op);
    return op == SB || op == SH || op == SW;
  endfunction

  function automatic logic mis(input logic [5:0] op, input logic [31:0] a);
    return (op == SH && a % 2 != 0) || (op == SW && a % 4 != 0);
  endfunction

  function automatic req_t model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] rt);
    req_t r;
    r.addr = (a >= 32'h8000_0000 && a < 32'hC000_0000) ? a % 32'h2000_0000 : a;
    if (op == SB) begin
      r.size  = 2'd0;
      r.wdata = (rt % 256) * 32'h0101_0101;
      r.wstrb = 4'(1 << (a % 4));
    end else if (op == SH) begin
      r.size  = 2'd1;
      r.wdata = (rt % 65536) * 32'h0001_0001;
      r.wstrb = (a % 4 >= 2) ? 4'hC : 4'h3;
    end else begin
      r.size  = 2'd2;
      r.wdata = rt;
      r.wstrb = 4'hF;
    end
    return r;
  endfunction

  // One pipeline cycle: a held instruction stays on the inputs while the unit stalls; flush turns it into a bubble.
  task automatic step(input logic v, input logic [5:0] op, input logic [31:0] a, input logic [31:0] rt,
                      input logic c, input logic f);
    logic exp_ades, exp_iss;
    @(negedge clk);
    if (new_instr) begin
      cv = v; cop = op; ca = a; crt = rt; cc = c;
    end
    st_valid = cv; st_op = cop; st_addr = ca; st_rt = crt; st_cancel = cc; flush = f;
    #4;
    exp_ades = cv && is_st(cop) && mis(cop, ca) && !cc;
    check("st_ades", 32'(st_ades), 32'(exp_ades));
    check("st_badvaddr", st_badvaddr, exp_ades ? ca : 32'h0);
    if (new_instr) begin
      exp_iss = cv && is_st(cop) && !mis(cop, ca) && !cc && !f;
      check("issue_stall", 32'(st_stall), 32'(exp_iss));
      if (exp_iss) q.push_back(model(cop, ca, crt));
    end
    new_instr = !st_stall;
    if (f) cv = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((outstanding != 0 || data_req || q.size() != 0 || !new_instr) && n < 300) begin
      step(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      n++;
    end
    check("drain_bound", 32'(n < 300), 32'd1);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      data_addr_ok = data_req && $urandom_range(0, 99) < p_aok;
      data_data_ok = (outstanding > 0 || data_addr_ok) ? $urandom_range(0, 99) < p_dok
                                                       : $urandom_range(0, 9) == 0;
    end
  end

  initial begin
    req_t cur;
    logic prev_req = 1'b0, prev_aok = 1'b0, prev_flush = 1'b0;
    forever begin
      @(negedge clk);
      #4;
      if (!resetn) begin
        outstanding = 0;
        q.delete();
        prev_req = 1'b0;
      end else begin
        if (data_req && !prev_req) begin
          check("overlap_outstanding", 32'(outstanding), 32'd0);
          if (q.size() == 0) begin
            check("unexpected_req", 32'(data_req), 32'd0);
          end else begin
            cur = q.pop_front();
            check("data_addr", data_addr, cur.addr);
            check("data_wdata", data_wdata, cur.wdata);
            check("data_size", 32'(data_size), 32'(cur.size));
            check("data_wstrb", 32'(data_wstrb), 32'(cur.wstrb));
            check("data_wr", 32'(data_wr), 32'd1);
          end
        end else if (data_req) begin
          check("stable_addr", data_addr, cur.addr);
          check("stable_wdata", data_wdata, cur.wdata);
          check("stable_wstrb", 32'(data_wstrb), 32'(cur.wstrb));
        end
        if (prev_req && !prev_aok && !prev_flush) check("req_held", 32'(data_req), 32'd1);
        if (prev_req && (prev_aok || prev_flush)) check("req_released", 32'(data_req), 32'd0);
        if (data_req) check("req_stall", 32'(st_stall), 32'(!(data_addr_ok && data_data_ok)));
        if (outstanding > 0 && !data_data_ok) check("wait_stall", 32'(st_stall), 32'd1);
        if (data_req && data_addr_ok) outstanding++;
        if (data_data_ok && outstanding > 0) outstanding--;
        prev_req = data_req; prev_aok = data_addr_ok; prev_flush = flush;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  op;
    logic [31:0] a;
    int          k;
    repeat (3) @(negedge clk);
    check("reset_req", 32'(data_req), 32'd0);
    check("reset_addr", data_addr, 32'd0);
    check("reset_stall", 32'(st_stall), 32'd0);
    resetn = 1'b1;

    p_aok = 100; p_dok = 100;
    step(1'b1, SB, 32'h8000_0003, 32'h1122_33AB, 1'b0, 1'b0);
    check("t1_issue_stall", 32'(st_stall), 32'd1);
    step(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    check("t1_req", 32'(data_req), 32'd1);
    check("t1_addr", data_addr, 32'h0000_0003);
    check("t1_wdata", data_wdata, 32'hABAB_ABAB);
    check("t1_wstrb", 32'(data_wstrb), 32'h8);
    check("t1_size", 32'(data_size), 32'd0);
    step(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    check("t1_done", 32'(data_req), 32'd0);

    step(1'b1, SW, 32'h8000_0006, 32'h1234_5678, 1'b0, 1'b0);
    check("t3_ades", 32'(st_ades), 32'd1);
    check("t3_badvaddr", st_badvaddr, 32'h8000_0006);
    step(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    check("t3_no_req", 32'(data_req), 32'd0);
    drain();

    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) begin
        p_aok = $urandom_range(20, 100);
        p_dok = $urandom_range(20, 100);
      end
      k  = $urandom_range(0, 9);
      op = k < 3 ? SB : k < 6 ? SH : k < 9 ? SW : 6'($urandom);
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a[31:30] = 2'b10;
      if ($urandom_range(0, 3) != 0) a[1:0] = op == SB ? a[1:0] : op == SH ? {a[1], 1'b0} : 2'b00;
      step($urandom_range(0, 9) < 8, op, a, $urandom, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
    end
    p_aok = 60; p_dok = 60;
    drain();

    p_aok = 100; p_dok = 0;
    step(1'b1, SW, 32'h0000_0010, 32'hCAFE_F00D, 1'b0, 1'b0);
    step(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    st_valid = 1'b0;
    #2 resetn = 1'b0;
    #1;
    check("t6_req", 32'(data_req), 32'd0);
    check("t6_wr", 32'(data_wr), 32'd0);
    check("t6_size", 32'(data_size), 32'd0);
    check("t6_addr", data_addr, 32'd0);
    check("t6_wdata", data_wdata, 32'd0);
    check("t6_wstrb", 32'(data_wstrb), 32'd0);
    check("t6_stall", 32'(st_stall), 32'd0);
    check("t6_ades", 32'(st_ades), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    new_instr = 1'b1;
    p_dok = 100;
    step(1'b1, SW, 32'h0000_0100, 32'h5555_AAAA, 1'b1, 1'b0);
    repeat (4) step(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    check("final_queue_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end
endmodule
